spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_slave_rx.sv | 98 +++++++++
 tb/tb_spi_slave_rx.sv | 125 ++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI mode-0 slave receiver/transmitter, MSB first, one WIDTH-bit word per CS-low frame.
// Ports: clk/rst system clock and sync active-high reset; SCLK/CS/MOSI async master inputs;
//        MISO serial reply; tx_data word returned next frame; rx_data last complete word;
//        rx_valid pulse on rx_data update; busy frame in progress; frame_err pulse on short frame.
module spi_slave_rx #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SCLK,
    input  logic             CS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             frame_err
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q, vld_q;
    logic                   sclk_prev_q, cs_prev_q, armed_q;
    logic [WIDTH-1:0]       rx_q, tx_q;
    logic [CW-1:0]          cnt_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;
    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign cs_s      = cs_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign MISO      = busy & tx_q[WIDTH-1];
    // vld_q marks when the synchronizer holds real pin samples rather than reset fill;
    // armed_q requires a genuine CS-high sample so a frame already in progress at reset release is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q      <= '0;
            cs_q        <= '1;
            mosi_q      <= '0;
            vld_q       <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            rx_q        <= '0;
            tx_q        <= '0;
            cnt_q       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], SCLK};
            cs_q        <= {cs_q[SYNC_STAGES-2:0], CS};
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], MOSI};
            vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            armed_q     <= armed_q | (vld_q[SYNC_STAGES-1] & cs_s);
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            unique case (state_q)
                IDLE: if (armed_q && cs_fall) begin
                    state_q <= SHIFT;
                    tx_q    <= tx_data;
                    cnt_q   <= '0;
                    busy    <= 1'b1;
                end
                SHIFT: begin
                    if (cnt_q == CW'(WIDTH)) begin
                        rx_data  <= rx_q;
                        rx_valid <= 1'b1;
                        state_q  <= HOLD;
                    end else if (cs_rise) begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state_q   <= IDLE;
                    end else if (sclk_rise) begin
                        rx_q  <= {rx_q[WIDTH-2:0], mosi_s};
                        cnt_q <= cnt_q + CW'(1);
                    end else if (sclk_fall) begin
                        tx_q <= {tx_q[WIDTH-2:0], 1'b0};
                    end
                end
                HOLD: if (cs_rise) begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: directed and random SPI master frames checked against a word-level model.
module tb_spi_slave_rx;
    logic       clk = 1'b0, rst = 1'b1, SCLK = 1'b0, CS = 1'b1, MOSI = 1'b0;
    logic       MISO, rx_valid, busy, frame_err;
    logic [3:0] tx_data = 4'h0, rx_data;
    int         tests = 0, fails = 0;
    int         vcnt = 0, ecnt = 0, both_cnt = 0;
    int         vexp = 0, eexp = 0;
    logic [3:0] rx_exp = 4'h0;
    logic [15:0] got;

    spi_slave_rx #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO),
        .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) vcnt++;
        if (frame_err) ecnt++;
        if (rx_valid && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [15:0] data, input int n, input int h, input bit loop,
                         input bit raise, input logic [3:0] tx_next, output logic [15:0] g);
        g  = '0;
        CS = 1'b0;
        clks(h);
        tx_data = tx_next;
        for (int i = 0; i < n; i++) begin
            if (!loop) MOSI = data[n-1-i];
            clks(h);
            if (loop) MOSI = MISO;
            g    = {g[14:0], MISO};
            SCLK = 1'b1;
            clks(h);
            SCLK = 1'b0;
        end
        if (raise) begin
            clks(h);
            CS = 1'b1;
            clks(h + 4);
        end
    endtask

    task automatic run_frame(input string tag, input logic [15:0] data, input int n, input int h,
                             input bit loop, input logic [3:0] txv, input logic [3:0] txn);
        int m;
        tx_data = txv;
        clks(2);
        frame(data, n, h, loop, 1'b1, txn, got);
        m = (n < 4) ? n : 4;
        if (n >= 4) begin
            vexp++;
            rx_exp = loop ? txv : data[n-1 -: 4];
        end else eexp++;
        chk({tag, "_rx_valid_count"}, 16'(vcnt), 16'(vexp));
        chk({tag, "_frame_err_count"}, 16'(ecnt), 16'(eexp));
        chk({tag, "_rx_data"}, {12'h0, rx_data}, {12'h0, rx_exp});
        chk({tag, "_miso_bits"}, got >> (n - m), 16'(txv) >> (4 - m));
        chk({tag, "_busy_after"}, {15'h0, busy}, 16'h0);
    endtask

    initial begin
        clks(4);
        chk("rst_rx_data", {12'h0, rx_data}, 16'h0);
        chk("rst_rx_valid", {15'h0, rx_valid}, 16'h0);
        chk("rst_busy", {15'h0, busy}, 16'h0);
        chk("rst_frame_err", {15'h0, frame_err}, 16'h0);
        chk("rst_miso", {15'h0, MISO}, 16'h0);
        rst = 1'b0;
        clks(6);
        run_frame("basic", 16'h6, 4, 8, 1'b0, 4'b1010, 4'h5);
        run_frame("loopback", 16'h0, 4, 6, 1'b1, 4'b1101, 4'h2);
        run_frame("short", 16'h3, 2, 5, 1'b0, 4'h7, 4'h8);
        run_frame("extra", 16'b100111, 6, 4, 1'b0, 4'hC, 4'h3);
        tx_data = 4'h9;
        clks(2);
        frame(16'h3, 2, 6, 1'b0, 1'b0, 4'h9, got);
        SCLK = 1'b1;
        clks(2);
        rst = 1'b1;
        clks(3);
        chk("midrst_rx_data", {12'h0, rx_data}, 16'h0);
        chk("midrst_busy", {15'h0, busy}, 16'h0);
        chk("midrst_miso", {15'h0, MISO}, 16'h0);
        rst    = 1'b0;
        rx_exp = 4'h0;
        clks(4);
        SCLK = 1'b0;
        clks(6);
        SCLK = 1'b1;
        clks(6);
        SCLK = 1'b0;
        clks(6);
        chk("postrst_busy", {15'h0, busy}, 16'h0);
        chk("postrst_frame_err_count", 16'(ecnt), 16'(eexp));
        CS = 1'b1;
        clks(8);
        run_frame("after_rst", 16'h3, 4, 7, 1'b0, 4'h6, 4'hF);
        run_frame("b2b_a", 16'hA, 4, 5, 1'b0, 4'h3, 4'h0);
        run_frame("b2b_5", 16'h5, 4, 5, 1'b0, 4'hC, 4'hF);
        for (int k = 0; k < 12; k++) begin
            int n = $urandom_range(1, 6);
            run_frame("random", 16'($urandom), n, $urandom_range(4, 10),
                      (n == 4) && ($urandom_range(0, 1) == 1), 4'($urandom), 4'($urandom));
        end
        chk("exclusive_pulses", 16'(both_cnt), 16'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
